complement_unit: RTL

COMPLEMENT_UNIT -- requirements
Module: complement_unit

---
 rtl/complement_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/complement_unit.sv
// Chunk-serial complement unit: pass, ones' complement, two's-complement negate
// or signed absolute value, processed CHUNK bits per cycle with a registered carry.
module complement_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum carries one extra bit on top so the carry-out can be registered.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                               input logic inv,
                                               input logic cin);
    chunk_add = {1'b0, (inv ? ~a : a)} + {{CHUNK{1'b0}}, cin};
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] op_r;
  logic [WIDTH-1:0] acc_r;
  logic             inv_r;
  logic             carry_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_ovf_r;
  logic             busy_r;

  logic             inv_s;
  logic             cin_s;
  logic [CHUNK-1:0] op_chunk_s;
  logic [CHUNK:0]   sum_s;
  logic [WIDTH-1:0] acc_next_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = busy_r;

  // Decode invert flag and initial carry from the incoming mode and sign bit.
  always_comb begin
    inv_s = 1'b0;
    cin_s = 1'b0;
    case (in_mode)
      2'b00: begin
        inv_s = 1'b0;
        cin_s = 1'b0;
      end
      2'b01: begin
        inv_s = 1'b1;
        cin_s = 1'b0;
      end
      2'b10: begin
        inv_s = 1'b1;
        cin_s = 1'b1;
      end
      2'b11: begin
        inv_s = in_data[WIDTH-1];
        cin_s = in_data[WIDTH-1];
      end
      default: begin
        inv_s = 1'b0;
        cin_s = 1'b0;
      end
    endcase
  end

  // Current chunk slice, its sum, and the accumulator with that chunk merged in.
  always_comb begin
    op_chunk_s = op_r[int'(cnt_r) * CHUNK +: CHUNK];
    sum_s      = chunk_add(op_chunk_s, inv_r, carry_r);
    acc_next_s = acc_r;
    acc_next_s[int'(cnt_r) * CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      op_r        <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      inv_r       <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r    <= in_data;
            inv_r   <= inv_s;
            carry_r <= cin_s;
            // Negating the most negative value wraps to itself.
            ovf_r   <= in_mode[1] && (in_data == MOST_NEG);
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          if (cnt_r == LAST_CHUNK) begin
            carry_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            out_data_r  <= acc_next_s;
            out_ovf_r   <= ovf_r;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            carry_r <= sum_s[CHUNK];
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
